// File: rtl/matmul_sched.sv
// ============================================================================
//  matmul_sched
//  Time-shares one vecmul engine across every element of a matrix product.
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_sched #(
   parameter int LEFT_SIZE  = 2,
   parameter int RIGHT_SIZE = 4,
   parameter int VM_LATENCY = 2,
   parameter int RW         = (LEFT_SIZE  > 1) ? $clog2(LEFT_SIZE)  : 1,
   parameter int CW         = (RIGHT_SIZE > 1) ? $clog2(RIGHT_SIZE) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_start,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_issue_valid,
   output logic [RW-1:0] o_issue_row,
   output logic [CW-1:0] o_issue_col,
   input  logic [31:0]   i_vm_result,
   output logic          o_wr_valid,
   output logic [RW-1:0] o_wr_row,
   output logic [CW-1:0] o_wr_col,
   output logic [31:0]   o_wr_data,
   input  logic          i_wr_ready
);

   localparam int c_n     = LEFT_SIZE * RIGHT_SIZE;
   localparam int c_depth = VM_LATENCY + 2;
   localparam int c_bw    = $clog2(c_n + 1);
   localparam int c_kw    = $clog2(2 * c_depth + 1);
   localparam int c_pw    = $clog2(c_depth);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_issue = 2'd1;
   localparam logic [1:0] c_st_drain = 2'd2;
   localparam logic [1:0] c_st_done  = 2'd3;

   logic [1:0]      r_state;
   logic [RW-1:0]   r_row;
   logic [CW-1:0]   r_col;
   logic [c_bw-1:0] r_beats;

   logic [VM_LATENCY-1:0] r_dl_v;
   logic [RW-1:0]         r_dl_row [VM_LATENCY];
   logic [CW-1:0]         r_dl_col [VM_LATENCY];

   logic [RW-1:0]   r_fifo_row  [c_depth];
   logic [CW-1:0]   r_fifo_col  [c_depth];
   logic [31:0]     r_fifo_data [c_depth];
   logic [c_pw-1:0] r_wp;
   logic [c_pw-1:0] r_rp;
   logic [c_kw-1:0] r_cnt;
   logic [c_kw-1:0] r_in_flight;

   logic [c_kw-1:0] w_occ;
   logic            w_issue;
   logic            w_last_col;
   logic            w_last_pair;
   logic            w_push;
   logic            w_wr_valid;
   logic            w_pop;

   // Credit is judged on cycle-start occupancy so the FIFO can never overflow.
   assign w_occ       = r_in_flight + r_cnt;
   assign w_issue     = (r_state == c_st_issue) && (w_occ < c_kw'(c_depth));
   assign w_last_col  = (r_col == CW'(RIGHT_SIZE - 1));
   assign w_last_pair = w_last_col && (r_row == RW'(LEFT_SIZE - 1));
   assign w_push      = r_dl_v[VM_LATENCY-1];
   assign w_wr_valid  = (r_cnt != '0);
   assign w_pop       = w_wr_valid && i_wr_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_st_idle;
         r_row   <= '0;
         r_col   <= '0;
         r_beats <= '0;
      end else begin
         if (w_pop) begin
            r_beats <= r_beats + c_bw'(1);
         end
         case (r_state)
            c_st_idle: begin
               if (i_start) begin
                  r_state <= c_st_issue;
                  r_row   <= '0;
                  r_col   <= '0;
                  r_beats <= '0;
               end
            end
            c_st_issue: begin
               if (w_issue) begin
                  if (w_last_pair) begin
                     r_state <= c_st_drain;
                  end else if (w_last_col) begin
                     r_col <= '0;
                     r_row <= r_row + RW'(1);
                  end else begin
                     r_col <= r_col + CW'(1);
                  end
               end
            end
            c_st_drain: begin
               if (w_pop && (r_beats == c_bw'(c_n - 1))) begin
                  r_state <= c_st_done;
               end
            end
            c_st_done: r_state <= c_st_idle;
            default:   r_state <= c_st_idle;
         endcase
      end
   end

   // Tag delay line runs in lockstep with the engine pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dl_v      <= '0;
         r_in_flight <= '0;
         for (int k = 0; k < VM_LATENCY; k++) begin
            r_dl_row[k] <= '0;
            r_dl_col[k] <= '0;
         end
      end else begin
         r_dl_v[0]   <= w_issue;
         r_dl_row[0] <= r_row;
         r_dl_col[0] <= r_col;
         for (int k = 1; k < VM_LATENCY; k++) begin
            r_dl_v[k]   <= r_dl_v[k-1];
            r_dl_row[k] <= r_dl_row[k-1];
            r_dl_col[k] <= r_dl_col[k-1];
         end
         r_in_flight <= r_in_flight + c_kw'(w_issue) - c_kw'(w_push);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_fifo_row[r_wp]  <= r_dl_row[VM_LATENCY-1];
            r_fifo_col[r_wp]  <= r_dl_col[VM_LATENCY-1];
            r_fifo_data[r_wp] <= i_vm_result;
            r_wp <= (r_wp == c_pw'(c_depth - 1)) ? '0 : r_wp + c_pw'(1);
         end
         if (w_pop) begin
            r_rp <= (r_rp == c_pw'(c_depth - 1)) ? '0 : r_rp + c_pw'(1);
         end
         r_cnt <= r_cnt + c_kw'(w_push) - c_kw'(w_pop);
      end
   end

   assign o_busy        = (r_state == c_st_issue) || (r_state == c_st_drain);
   assign o_done        = (r_state == c_st_done);
   assign o_issue_valid = w_issue;
   assign o_issue_row   = r_row;
   assign o_issue_col   = r_col;
   assign o_wr_valid    = w_wr_valid;
   assign o_wr_row      = w_wr_valid ? r_fifo_row[r_rp]  : '0;
   assign o_wr_col      = w_wr_valid ? r_fifo_col[r_rp]  : '0;
   assign o_wr_data     = w_wr_valid ? r_fifo_data[r_rp] : '0;

endmodule

`default_nettype wire

// File: tb/tb_matmul_sched.sv
// ============================================================================
//  tb_matmul_sched
//  Directed self-checking bench for matmul_sched (default and 1x1 builds).
//  Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matmul_sched;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start;
   logic        o_busy, o_done, o_issue_valid;
   logic [0:0]  o_issue_row;
   logic [1:0]  o_issue_col;
   logic [31:0] i_vm_result;
   logic        o_wr_valid;
   logic [0:0]  o_wr_row;
   logic [1:0]  o_wr_col;
   logic [31:0] o_wr_data;
   logic        i_wr_ready;

   logic        i2_start;
   logic        o2_busy, o2_done, o2_issue_valid;
   logic [0:0]  o2_issue_row, o2_issue_col;
   logic [31:0] i2_vm_result;
   logic        o2_wr_valid;
   logic [0:0]  o2_wr_row, o2_wr_col;
   logic [31:0] o2_wr_data;
   logic        i2_wr_ready;

   int n_cmp = 0;
   int n_mis = 0;

   logic [31:0] exp_data [8] = '{32'd1, 32'd2, 32'd3, 32'd6, 32'd4, 32'd5, 32'd6, 32'd15};
   logic [31:0] vm_p1 = '0;
   logic [31:0] vm_p2 = '0;
   logic [31:0] vm2_p1 = '0;

   always #5 clk = ~clk;

   matmul_sched dut (
      .clk(clk), .rst(rst), .i_start(i_start),
      .o_busy(o_busy), .o_done(o_done),
      .o_issue_valid(o_issue_valid), .o_issue_row(o_issue_row), .o_issue_col(o_issue_col),
      .i_vm_result(i_vm_result),
      .o_wr_valid(o_wr_valid), .o_wr_row(o_wr_row), .o_wr_col(o_wr_col),
      .o_wr_data(o_wr_data), .i_wr_ready(i_wr_ready)
   );

   matmul_sched #(.LEFT_SIZE(1), .RIGHT_SIZE(1), .VM_LATENCY(1)) dut2 (
      .clk(clk), .rst(rst), .i_start(i2_start),
      .o_busy(o2_busy), .o_done(o2_done),
      .o_issue_valid(o2_issue_valid), .o_issue_row(o2_issue_row), .o_issue_col(o2_issue_col),
      .i_vm_result(i2_vm_result),
      .o_wr_valid(o2_wr_valid), .o_wr_row(o2_wr_row), .o_wr_col(o2_wr_col),
      .o_wr_data(o2_wr_data), .i_wr_ready(i2_wr_ready)
   );

   // Engine model: in1[r][k] = 3r+k+1, in2 = [I | ones] (3x4).
   function automatic logic [31:0] dot(input int r, input int c);
      int s;
      s = 0;
      for (int k = 0; k < 3; k++) begin
         s += (3 * r + k + 1) * ((c == 3) ? 1 : ((k == c) ? 1 : 0));
      end
      return 32'(s);
   endfunction

   always @(posedge clk) begin
      vm_p1  <= o_issue_valid ? dot(int'(o_issue_row), int'(o_issue_col)) : 32'hBAD0_0000;
      vm_p2  <= vm_p1;
      vm2_p1 <= o2_issue_valid ? 32'h1234_5678 : 32'hBAD0_0001;
   end
   assign i_vm_result  = vm_p2;
   assign i2_vm_result = vm2_p1;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_mis++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},   32'(o_busy),        0);
      chk({tag, "_done"},   32'(o_done),        0);
      chk({tag, "_ivalid"}, 32'(o_issue_valid), 0);
      chk({tag, "_irow"},   32'(o_issue_row),   0);
      chk({tag, "_icol"},   32'(o_issue_col),   0);
      chk({tag, "_wvalid"}, 32'(o_wr_valid),    0);
      chk({tag, "_wrow"},   32'(o_wr_row),      0);
      chk({tag, "_wcol"},   32'(o_wr_col),      0);
      chk({tag, "_wdata"},  o_wr_data,          0);
   endtask

   // mode 0: ready=1 cycle-exact; 1: random ready; 2: ready from cycle 20; 3: like 0, start held
   task automatic run_product(input int mode);
      int          cyc, beats, issued, dones, done_cyc;
      logic        stall;
      logic [31:0] h_row, h_col, h_data;
      cyc = 1; beats = 0; issued = 0; dones = 0; done_cyc = 0; stall = 1'b0;
      h_row = '0; h_col = '0; h_data = '0;
      i_start = 1'b1;
      step();
      i_start = (mode == 3);
      while (dones == 0 && cyc < 600) begin
         case (mode)
            1:       i_wr_ready = 1'($urandom_range(0, 1));
            2:       i_wr_ready = (cyc >= 20);
            default: i_wr_ready = 1'b1;
         endcase
         if (mode == 0 || mode == 3) begin
            chk("t_ivalid", 32'(o_issue_valid), 32'(cyc <= 8));
            chk("t_wvalid", 32'(o_wr_valid), 32'(cyc >= 4 && cyc <= 11));
            chk("t_busy", 32'(o_busy), 32'(cyc <= 11));
         end
         if (mode == 2 && cyc < 20) begin
            chk("stall_ivalid", 32'(o_issue_valid), 32'(cyc <= 4));
            if (cyc > 4) begin
               chk("stall_irow", 32'(o_issue_row), 1);
               chk("stall_icol", 32'(o_issue_col), 0);
            end
         end
         if (o_issue_valid) begin
            chk("issue_row", 32'(o_issue_row), 32'(issued / 4));
            chk("issue_col", 32'(o_issue_col), 32'(issued % 4));
            issued++;
         end
         if (stall) begin
            chk("hold_valid", 32'(o_wr_valid), 1);
            chk("hold_row", 32'(o_wr_row), h_row);
            chk("hold_col", 32'(o_wr_col), h_col);
            chk("hold_data", o_wr_data, h_data);
         end
         stall  = o_wr_valid && !i_wr_ready;
         h_row  = 32'(o_wr_row);
         h_col  = 32'(o_wr_col);
         h_data = o_wr_data;
         if (o_wr_valid && i_wr_ready) begin
            chk("beat_row", 32'(o_wr_row), 32'(beats / 4));
            chk("beat_col", 32'(o_wr_col), 32'(beats % 4));
            chk("beat_data", o_wr_data, (beats < 8) ? exp_data[beats] : 32'hFFFF_FFFF);
            beats++;
         end
         chk("credit", 32'((issued - beats) <= 4), 1);
         if (o_done) begin
            dones++;
            done_cyc = cyc;
            chk("done_busy", 32'(o_busy), 0);
         end
         step();
         cyc++;
      end
      chk("n_done", 32'(dones), 1);
      chk("n_beats", 32'(beats), 8);
      chk("n_issued", 32'(issued), 8);
      chk("post_done", 32'(o_done), 0);
      chk("post_busy", 32'(o_busy), 0);
      if (mode == 0 || mode == 3) chk("done_cycle", 32'(done_cyc), 12);
   endtask

   initial begin
      rst = 1'b1; i_start = 1'b0; i_wr_ready = 1'b1;
      i2_start = 1'b0; i2_wr_ready = 1'b1;
      step(); step(); step();
      chk_zero("reset");
      rst = 1'b0;
      step();

      run_product(0);
      run_product(2);

      // Abort a product mid-flight; stale engine data must not surface.
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1;
      step();
      chk_zero("midrst");
      rst = 1'b0;
      run_product(0);

      run_product(3);
      chk("idle_gap_busy", 32'(o_busy), 0);
      run_product(3);
      i_start = 1'b0;
      step();
      chk("after_held_busy", 32'(o_busy), 0);

      for (int p = 0; p < 200; p++) run_product(1);

      i2_start = 1'b1;
      step();
      i2_start = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         chk("n1_ivalid", 32'(o2_issue_valid), 32'(c == 1));
         chk("n1_wvalid", 32'(o2_wr_valid), 32'(c == 3));
         chk("n1_done", 32'(o2_done), 32'(c == 4));
         chk("n1_busy", 32'(o2_busy), 32'(c <= 3));
         if (c == 3) begin
            chk("n1_data", o2_wr_data, 32'h1234_5678);
            chk("n1_tag", 32'({o2_wr_row, o2_wr_col}), 0);
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

`default_nettype wire
